// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file widths, RegWrite enable bit, writeback entry.
package cpu_pkg;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned REG_DW    = 32;
  localparam int unsigned RW_EN_BIT = 1;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Writeback / mul-div / hazard-query bundle for reg_write_arbiter.
// Optional forwarding signals appear only when REG_WRITE_ARB_FWD_EN is defined.
interface reg_write_arbiter_if
  import cpu_pkg::*;
#(
  parameter int unsigned AW = REG_AW,
  parameter int unsigned DW = REG_DW
);

  logic          wb_valid_i;
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_data_i;
  logic          md_valid_i;
  logic          md_ready_o;
  logic [AW-1:0] md_addr_i;
  logic [DW-1:0] md_data_i;
  logic [AW-1:0] rs_addr_i;
  logic [AW-1:0] rt_addr_i;
  logic          rs_pending_o;
  logic          rt_pending_o;
  logic [AW-1:0] RDaddr_o;
  logic [DW-1:0] RDdata_o;
  logic [1:0]    RegWrite_o;
`ifdef REG_WRITE_ARB_FWD_EN
  logic          rs_fwd_o;
  logic          rt_fwd_o;
  logic [DW-1:0] fwd_data_o;
`endif

  // Producer / hazard-unit / register-file side
  modport master (
    output wb_valid_i, wb_addr_i, wb_data_i,
    output md_valid_i, md_addr_i, md_data_i,
    output rs_addr_i, rt_addr_i,
    input  md_ready_o, rs_pending_o, rt_pending_o,
`ifdef REG_WRITE_ARB_FWD_EN
    input  rs_fwd_o, rt_fwd_o, fwd_data_o,
`endif
    input  RDaddr_o, RDdata_o, RegWrite_o
  );

  // Arbiter side
  modport slave (
    input  wb_valid_i, wb_addr_i, wb_data_i,
    input  md_valid_i, md_addr_i, md_data_i,
    input  rs_addr_i, rt_addr_i,
    output md_ready_o, rs_pending_o, rt_pending_o,
`ifdef REG_WRITE_ARB_FWD_EN
    output rs_fwd_o, rt_fwd_o, fwd_data_o,
`endif
    output RDaddr_o, RDdata_o, RegWrite_o
  );

endinterface

// File: rtl/reg_wb_fifo.sv
// DEPTH-entry circular buffer of pending mul/div writebacks.
// All entries and their valid bits are exposed for the hazard compare.
module reg_wb_fifo
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  output wb_entry_t                   head,
  output logic      [CW-1:0]          count,
  output wb_entry_t [DEPTH-1:0]       entries,
  output logic      [DEPTH-1:0]       valid
);

  wb_entry_t [DEPTH-1:0] mem;
  logic      [PW-1:0]    wr_ptr;
  logic      [PW-1:0]    rd_ptr;
  logic      [DEPTH-1:0] valid_nxt;

  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Next valid map: retire the head on pop, claim the tail on push
  always_comb begin
    valid_nxt = valid;
    if (pop)  valid_nxt[rd_ptr] = 1'b0;
    if (push) valid_nxt[wr_ptr] = 1'b1;
  end

  // Pointers, occupancy and valid bits; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      valid <= valid_nxt;
    end
  end

  // Entry storage; contents are qualified by valid so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Merges pipeline writeback and buffered mul/div results onto the single
// register-file write port, and flags registers with undrained mul/div writes.
// Optional macro REG_WRITE_ARB_FWD_EN adds forwarding of the write on the port.
module reg_write_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = REG_DW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  reg_write_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_entry_t              fifo_head;
  logic      [CW-1:0]     fifo_count;
  wb_entry_t [DEPTH-1:0]  fifo_entries;
  logic      [DEPTH-1:0]  fifo_valid;
  logic                   fifo_push;
  logic                   fifo_pop;

  wb_entry_t              wb_entry;
  wb_entry_t              md_entry;
  wb_entry_t              sel_entry;
  logic                   sel_valid;
  logic                   md_ready_c;
  logic                   md_fire_c;

  logic                   we_q;
  logic      [REG_AW-1:0] addr_q;
  logic      [REG_DW-1:0] data_q;
  logic      [1:0]        regwrite;

  logic                   rs_hit;
  logic                   rt_hit;

  assign wb_entry = '{addr: REG_AW'(bus.wb_addr_i), data: REG_DW'(bus.wb_data_i)};
  assign md_entry = '{addr: REG_AW'(bus.md_addr_i), data: REG_DW'(bus.md_data_i)};

  // Acceptance depends only on occupancy, never on a same-cycle pop
  assign md_ready_c     = rst_i & (fifo_count != CW'(DEPTH));
  assign md_fire_c      = bus.md_valid_i & md_ready_c;
  assign bus.md_ready_o = md_ready_c;

  reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (fifo_push),
    .push_entry (md_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_count),
    .entries    (fifo_entries),
    .valid      (fifo_valid)
  );

  // Write-port selection: pipeline first, then FIFO head, then direct mul/div bypass
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = '0;
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;
    if (bus.wb_valid_i) begin
      sel_valid = 1'b1;
      sel_entry = wb_entry;
      fifo_push = md_fire_c;
    end else if (fifo_count != '0) begin
      sel_valid = 1'b1;
      sel_entry = fifo_head;
      fifo_pop  = 1'b1;
      fifo_push = md_fire_c;
    end else if (md_fire_c) begin
      sel_valid = 1'b1;
      sel_entry = md_entry;
    end
  end

  // Registered write port; address/data hold when idle
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (sel_valid) begin
      we_q   <= 1'b1;
      addr_q <= sel_entry.addr;
      data_q <= sel_entry.data;
    end else begin
      we_q   <= 1'b0;
    end
  end

  // Place the enable on its RegWrite bit; the other bit stays 0
  always_comb begin
    regwrite            = '0;
    regwrite[RW_EN_BIT] = we_q;
  end

  assign bus.RegWrite_o = regwrite;
  assign bus.RDaddr_o   = AW'(addr_q);
  assign bus.RDdata_o   = DW'(data_q);

  // Pending compare of both hazard queries against every live FIFO entry
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (fifo_valid[i] && (fifo_entries[i].addr == REG_AW'(bus.rs_addr_i))) rs_hit = 1'b1;
      if (fifo_valid[i] && (fifo_entries[i].addr == REG_AW'(bus.rt_addr_i))) rt_hit = 1'b1;
    end
  end

  assign bus.rs_pending_o = rst_i & rs_hit & (bus.rs_addr_i != '0);
  assign bus.rt_pending_o = rst_i & rt_hit & (bus.rt_addr_i != '0);

`ifdef REG_WRITE_ARB_FWD_EN
  // Bypass of the write being committed this cycle to the decode stage
  assign bus.rs_fwd_o   = we_q & (addr_q == REG_AW'(bus.rs_addr_i)) & (bus.rs_addr_i != '0);
  assign bus.rt_fwd_o   = we_q & (addr_q == REG_AW'(bus.rt_addr_i)) & (bus.rt_addr_i != '0);
  assign bus.fwd_data_o = DW'(data_q);
`endif

endmodule
